// File: rtl/fifo_ctrl_pkg.sv
// fifo_ctrl_pkg
//   Shared types and constants for the FIFO write-side control blocks.
//   - arb_state_t : sequencer states of fifo_wr_arbiter
//   - DEF_WIDTH   : default data width, matches the async_fifo WIDTH
//   - DEF_DEPTH   : default FIFO depth, shared with the FIFO testbench
//   - idx_width() : width of an index able to address n entries (min 1)
package fifo_ctrl_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        BACKOFF = 2'd3
    } arb_state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
//   Stateless rotate-priority selector. The requester at index ptr_i has the
//   highest priority, then ptr_i+1, ... wrapping modulo NREQ. The pointer
//   register itself lives in the parent.
//   Ports:
//     req_i     [NREQ]  : request vector
//     ptr_i     [IDX_W] : highest-priority index (must be < NREQ)
//     sel_oh_o  [NREQ]  : one-hot winner (all zero when no request)
//     sel_idx_o [IDX_W] : winner index (0 when no request)
//     any_o             : at least one request present
module rr_arbiter
    import fifo_ctrl_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int IDX_W = idx_width(NREQ)
)(
    input  logic [NREQ-1:0]  req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [NREQ-1:0]  sel_oh_o,
    output logic [IDX_W-1:0] sel_idx_o,
    output logic             any_o
);

    // One extra bit so ptr + offset never overflows before the wrap.
    localparam int            SW     = IDX_W + 1;
    localparam logic [SW-1:0] NREQ_W = SW'(NREQ);

    logic [SW-1:0]    sum;
    logic [IDX_W-1:0] pos;
    logic             found;

    always_comb begin
        sel_oh_o  = '0;
        sel_idx_o = '0;
        found     = 1'b0;
        sum       = '0;
        pos       = '0;
        for (int k = 0; k < NREQ; k++) begin
            sum = {1'b0, ptr_i} + SW'(k);
            if (sum >= NREQ_W) begin
                sum = sum - NREQ_W;
            end
            pos = sum[IDX_W-1:0];
            if (!found && req_i[pos]) begin
                sel_oh_o[pos] = 1'b1;
                sel_idx_o     = pos;
                found         = 1'b1;
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Round-robin arbiter and write sequencer sharing the write side of one
//   async_fifo between NREQ requesters. A winner's data is captured, written
//   with a single-cycle wr_en, and the FIFO's wr_ack/wr_err handshake is
//   awaited. Errors (wr_err or no response within TIMEOUT cycles) are retried
//   up to MAX_RETRY times before fail is reported. All outputs are registered.
//   Ports:
//     wr_clk_i        : clock
//     clear_i         : asynchronous active-high reset
//     req_i      [N]  : level requests, held until done/fail
//     req_data_i [N*W]: requester i data at [i*WIDTH +: WIDTH]
//     gnt_o      [N]  : one-hot pulse when data is captured and first written
//     done_o     [N]  : pulse when the write is acknowledged
//     fail_o     [N]  : pulse when retries are exhausted
//     fifo_din_o [W]  : FIFO din
//     fifo_wr_en_o    : FIFO wr_en, single-cycle pulse
//     fifo_full_i     : FIFO full
//     fifo_wr_ack_i   : FIFO wr_ack
//     fifo_wr_err_i   : FIFO wr_err
//     busy_o          : high in every state except IDLE
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   IDLE    | no transaction; arbitrate when a request is present and !full
//   ISSUE   | wr_en pulse on the FIFO; timeout counter loaded
//   WAIT    | waiting for wr_ack / wr_err / timeout
//   BACKOFF | error seen, retry pending; re-issue once the FIFO is not full
module fifo_wr_arbiter
    import fifo_ctrl_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int WIDTH     = DEF_WIDTH,
    parameter int TIMEOUT   = 4,
    parameter int MAX_RETRY = 3
)(
    input  logic                  wr_clk_i,
    input  logic                  clear_i,
    input  logic [NREQ-1:0]       req_i,
    input  logic [NREQ*WIDTH-1:0] req_data_i,
    output logic [NREQ-1:0]       gnt_o,
    output logic [NREQ-1:0]       done_o,
    output logic [NREQ-1:0]       fail_o,
    output logic [WIDTH-1:0]      fifo_din_o,
    output logic                  fifo_wr_en_o,
    input  logic                  fifo_full_i,
    input  logic                  fifo_wr_ack_i,
    input  logic                  fifo_wr_err_i,
    output logic                  busy_o
);

    localparam int IDX_W = idx_width(NREQ);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam int RTY_W = 3;

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NREQ - 1);
    localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(TIMEOUT);
    localparam logic [RTY_W-1:0] RTY_LIMIT = RTY_W'(MAX_RETRY);

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] sel_q,   sel_d;
    logic [IDX_W-1:0] ptr_q,   ptr_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [RTY_W-1:0] rty_q,   rty_d;
    logic [NREQ-1:0]  gnt_q,   gnt_d;
    logic [NREQ-1:0]  done_q,  done_d;
    logic [NREQ-1:0]  fail_q,  fail_d;
    logic [WIDTH-1:0] din_q,   din_d;
    logic             wr_en_q, wr_en_d;
    logic             busy_q,  busy_d;

    logic [NREQ-1:0]  arb_oh;
    logic [IDX_W-1:0] arb_idx;
    logic             arb_any;
    logic [IDX_W-1:0] ptr_after_sel;
    logic             wait_error;

    rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .req_i     (req_i),
        .ptr_i     (ptr_q),
        .sel_oh_o  (arb_oh),
        .sel_idx_o (arb_idx),
        .any_o     (arb_any)
    );

    // The finished requester drops to lowest priority.
    assign ptr_after_sel = (sel_q == LAST_IDX) ? '0 : sel_q + 1'b1;

    // The counter holds TIMEOUT in the first WAIT cycle, so reaching 1 here
    // means the decrement to 0 happens in the TIMEOUT-th WAIT cycle.
    assign wait_error = fifo_wr_err_i || (cnt_q == CNT_W'(1));

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        rty_d   = rty_q;
        din_d   = din_q;
        gnt_d   = '0;
        done_d  = '0;
        fail_d  = '0;
        wr_en_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (arb_any && !fifo_full_i) begin
                    sel_d   = arb_idx;
                    din_d   = req_data_i[arb_idx*WIDTH +: WIDTH];
                    gnt_d   = arb_oh;
                    wr_en_d = 1'b1;
                    state_d = ISSUE;
                end
            end

            ISSUE: begin
                cnt_d   = CNT_LOAD;
                state_d = WAIT;
            end

            WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (fifo_wr_ack_i) begin
                    done_d[sel_q] = 1'b1;
                    ptr_d         = ptr_after_sel;
                    rty_d         = '0;
                    state_d       = IDLE;
                end else if (wait_error) begin
                    if (rty_q < RTY_LIMIT) begin
                        rty_d   = rty_q + 1'b1;
                        state_d = BACKOFF;
                    end else begin
                        fail_d[sel_q] = 1'b1;
                        ptr_d         = ptr_after_sel;
                        rty_d         = '0;
                        state_d       = IDLE;
                    end
                end
            end

            BACKOFF: begin
                // Retry reuses the captured data in din_q; no new grant.
                if (!fifo_full_i) begin
                    wr_en_d = 1'b1;
                    state_d = ISSUE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge wr_clk_i or posedge clear_i) begin
        if (clear_i) begin
            state_q <= IDLE;
            sel_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            rty_q   <= '0;
            din_q   <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            fail_q  <= '0;
            wr_en_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            rty_q   <= rty_d;
            din_q   <= din_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            fail_q  <= fail_d;
            wr_en_q <= wr_en_d;
            busy_q  <= busy_d;
        end
    end

    assign gnt_o        = gnt_q;
    assign done_o       = done_q;
    assign fail_o       = fail_q;
    assign fifo_din_o   = din_q;
    assign fifo_wr_en_o = wr_en_q;
    assign busy_o       = busy_q;

endmodule
